// File: rtl/ir_pkg.sv
// Shared instruction-word layout for the 16-bit multicycle processor:
// field bit positions, decoded field bundle and the decode helper.
package ir_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam int unsigned OPC_HI  = 15;
  localparam int unsigned OPC_LO  = 12;
  localparam int unsigned FUNC_HI = 3;
  localparam int unsigned FUNC_LO = 0;
  localparam int unsigned RR1_HI  = 7;
  localparam int unsigned RR1_LO  = 4;
  localparam int unsigned RR2_HI  = 3;
  localparam int unsigned RR2_LO  = 0;
  localparam int unsigned OFF_HI  = 9;
  localparam int unsigned OFF_LO  = 8;
  localparam int unsigned SWLW_HI = 11;
  localparam int unsigned SWLW_LO = 10;
  localparam int unsigned WR_HI   = 11;
  localparam int unsigned WR_LO   = 8;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] funcfield;
    logic [3:0] read_reg1;
    logic [3:0] read_reg2;
    logic [1:0] offset;
    logic [1:0] reg_swlw;
    logic [3:0] write_reg;
  } ir_fields_t;

  function automatic ir_fields_t decode_ir(input logic [INSTR_W-1:0] w);
    ir_fields_t f;
    f.opcode    = w[OPC_HI:OPC_LO];
    f.funcfield = w[FUNC_HI:FUNC_LO];
    f.read_reg1 = w[RR1_HI:RR1_LO];
    f.read_reg2 = w[RR2_HI:RR2_LO];
    f.offset    = w[OFF_HI:OFF_LO];
    f.reg_swlw  = w[SWLW_HI:SWLW_LO];
    f.write_reg = w[WR_HI:WR_LO];
    return f;
  endfunction

endpackage

// File: rtl/ir_fifo.sv
// DEPTH-entry prefetch FIFO holding {pc, instr} pairs; DEPTH need not be a
// power of two, so pointers wrap explicitly. clr empties it synchronously.
module ir_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];
  assign count = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_queue_reg.sv
// Instruction register with prefetch queue: registered IR stage fed either
// from the FIFO head or, when the FIFO is empty, directly from fetch.
module instr_queue_reg
  import ir_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [AW-1:0]              in_pc,
  input  logic                       advance,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [3:0]                 opcode,
  output logic [3:0]                 funcfield,
  output logic [3:0]                 read_reg1,
  output logic [3:0]                 read_reg2,
  output logic [1:0]                 offset,
  output logic [1:0]                 reg_swlw,
  output logic [3:0]                 write_reg,
  output logic [$clog2(DEPTH+2)-1:0] count
);

  localparam int unsigned FCW = $clog2(DEPTH+1);
  localparam int unsigned CW  = $clog2(DEPTH+2);
  localparam int unsigned EW  = INSTR_W + AW;

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [AW-1:0]      pc_q, pc_d;
  ir_fields_t         fld_q, fld_d;

  logic           fifo_full, fifo_empty;
  logic [EW-1:0]  fifo_head;
  logic [FCW-1:0] fifo_cnt;
  logic           xfer_in, consume, load, pop, bypass, push;

  // in_ready depends only on registered occupancy and flush, never on advance.
  assign in_ready = !fifo_full && !flush;
  assign xfer_in  = in_valid && in_ready;
  assign consume  = advance && valid_q;
  assign load     = (!valid_q || consume) && !flush;
  assign pop      = load && !fifo_empty;
  assign bypass   = load && fifo_empty && xfer_in;
  assign push     = xfer_in && !bypass;

  ir_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_pc, in_instr}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_cnt)
  );

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = pop || bypass;
      if (pop) begin
        instr_d = fifo_head[INSTR_W-1:0];
        pc_d    = fifo_head[EW-1:INSTR_W];
      end else if (bypass) begin
        instr_d = in_instr;
        pc_d    = in_pc;
      end
    end
    fld_d = decode_ir(instr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      fld_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fld_q   <= fld_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign opcode    = fld_q.opcode;
  assign funcfield = fld_q.funcfield;
  assign read_reg1 = fld_q.read_reg1;
  assign read_reg2 = fld_q.read_reg2;
  assign offset    = fld_q.offset;
  assign reg_swlw  = fld_q.reg_swlw;
  assign write_reg = fld_q.write_reg;
  assign count     = CW'(fifo_cnt) + CW'(valid_q);

endmodule

// File: tb/tb_instr_queue_reg.sv
// Directed bench for instr_queue_reg (DEPTH=4, AW=8): reset, bypass, fill,
// flush, streaming with pointer wrap, drain and asynchronous reset.
module tb_instr_queue_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, advance, flush, out_valid;
  logic [15:0] in_instr, out_instr;
  logic [7:0]  in_pc, out_pc;
  logic [3:0]  opcode, funcfield, read_reg1, read_reg2, write_reg;
  logic [1:0]  offset, reg_swlw;
  logic [2:0]  count;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  instr_queue_reg #(.DEPTH(4), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .advance(advance), .flush(flush),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .funcfield(funcfield), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .offset(offset), .reg_swlw(reg_swlw),
    .write_reg(write_reg), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic [7:0] p);
    in_valid = v;
    in_instr = w;
    in_pc    = p;
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; flush = 1'b0;
    drive(1'b0, 16'h0000, 8'h00);

    // Reset state
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_pc", {24'd0, out_pc}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    #10 rst = 1'b0;

    // Bypass into an empty system
    drive(1'b1, 16'h3A5C, 8'h10);
    step();
    drive(1'b0, 16'h0000, 8'h00);
    chk("byp_valid", {31'd0, out_valid}, 32'd1);
    chk("byp_opcode", {28'd0, opcode}, 32'h3);
    chk("byp_swlw", {30'd0, reg_swlw}, 32'h2);
    chk("byp_offset", {30'd0, offset}, 32'h2);
    chk("byp_wr", {28'd0, write_reg}, 32'hA);
    chk("byp_rr1", {28'd0, read_reg1}, 32'h5);
    chk("byp_rr2", {28'd0, read_reg2}, 32'hC);
    chk("byp_func", {28'd0, funcfield}, 32'hC);
    chk("byp_pc", {24'd0, out_pc}, 32'h10);
    chk("byp_count", {29'd0, count}, 32'd1);

    // Consume with nothing behind it, then advance on an empty IR
    advance = 1'b1;
    step();
    chk("drain1_valid", {31'd0, out_valid}, 32'd0);
    chk("drain1_count", {29'd0, count}, 32'd0);
    step();
    chk("idleadv_valid", {31'd0, out_valid}, 32'd0);
    chk("idleadv_count", {29'd0, count}, 32'd0);
    chk("idleadv_hold", {16'd0, out_instr}, 32'h3A5C);
    advance = 1'b0;

    // Fill: W0 bypasses, W1..W4 queue, W5 is held
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 8'h20 + 8'(i));
      step();
    end
    chk("fill_count", {29'd0, count}, 32'd5);
    chk("fill_ir", {16'd0, out_instr}, 32'h1000);
    drive(1'b1, 16'h1005, 8'h25);
    #1;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("full_hold_cnt", {29'd0, count}, 32'd5);
    chk("full_hold_ir", {16'd0, out_instr}, 32'h1000);
    advance = 1'b1;
    #1;
    chk("full_adv_ready", {31'd0, in_ready}, 32'd0);
    step();
    advance = 1'b0;
    chk("pop1_ir", {16'd0, out_instr}, 32'h1001);
    chk("pop1_pc", {24'd0, out_pc}, 32'h21);
    chk("pop1_count", {29'd0, count}, 32'd4);
    chk("pop1_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("w5_count", {29'd0, count}, 32'd5);

    // Flush while full with input offered and advance high
    drive(1'b1, 16'hDEAD, 8'hEE);
    advance = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    advance = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_hold", {16'd0, out_instr}, 32'h1001);
    drive(1'b1, 16'h7B21, 8'h40);
    step();
    chk("postfl_valid", {31'd0, out_valid}, 32'd1);
    chk("postfl_ir", {16'd0, out_instr}, 32'h7B21);
    chk("postfl_opc", {28'd0, opcode}, 32'h7);
    chk("postfl_count", {29'd0, count}, 32'd1);

    // Streaming: preload S0,S1 then push/pop every cycle for 20 cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h5000 + 16'(i), 8'h80 + 8'(i));
      step();
    end
    chk("pre_count", {29'd0, count}, 32'd3);
    advance = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 16'h5000 + 16'(k + 2), 8'h80 + 8'(k + 2));
      step();
      chk("strm_ir", {16'd0, out_instr}, 32'h5000 + 32'(k));
      chk("strm_pc", {24'd0, out_pc}, 32'h80 + 32'(k));
      chk("strm_count", {29'd0, count}, 32'd3);
    end

    // Drain with advance held and no input
    drive(1'b0, 16'h0000, 8'h00);
    step();
    chk("dr_ir20", {16'd0, out_instr}, 32'h5014);
    chk("dr_cnt2", {29'd0, count}, 32'd2);
    step();
    chk("dr_ir21", {16'd0, out_instr}, 32'h5015);
    chk("dr_cnt1", {29'd0, count}, 32'd1);
    step();
    chk("dr_valid", {31'd0, out_valid}, 32'd0);
    chk("dr_cnt0", {29'd0, count}, 32'd0);
    chk("dr_hold", {16'd0, out_instr}, 32'h5015);
    advance = 1'b0;

    // Asynchronous reset with three entries queued behind the IR
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h2000 + 16'(i), 8'h60 + 8'(i));
      step();
    end
    drive(1'b0, 16'h0000, 8'h00);
    chk("prerst_count", {29'd0, count}, 32'd4);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_instr", {16'd0, out_instr}, 32'd0);
    #2 rst = 1'b0;
    drive(1'b1, 16'hC3F0, 8'h77);
    step();
    drive(1'b0, 16'h0000, 8'h00);
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_ir", {16'd0, out_instr}, 32'hC3F0);
    chk("postrst_wr", {28'd0, write_reg}, 32'h3);
    chk("postrst_count", {29'd0, count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
